// File: rtl/fp_adder_pkg.sv
// Shared definitions for the FP adder normaliser: result flag bit positions and
// the leading-one-position to left-shift mapping.
package fp_adder_pkg;

    localparam int unsigned FLAG_W      = 3;
    localparam int unsigned FLAG_ZERO   = 0;
    localparam int unsigned FLAG_UFLOW  = 1;
    localparam int unsigned FLAG_DENORM = 2;

    // A leading one at index pos-1 needs width-pos left shifts to reach the MSB.
    function automatic int unsigned pos_to_shift(input int unsigned pos,
                                                 input int unsigned width);
        return width - pos;
    endfunction

endpackage

// File: rtl/fp_lzd.sv
// Combinational leading-one detector: returns highest set bit index + 1, or 0
// when the input is all zeros.
module fp_lzd #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned POS_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] mant,
    output logic [POS_W-1:0] pos
);

    always_comb begin
        pos = '0;
        // Ascending scan, so the highest set bit is the last to write pos.
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (mant[i]) begin
                pos = POS_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/fp_adder_normalizer.sv
// Two-stage valid/ready mantissa normaliser. Defining FP_ADDER_NORMALIZER_DENORM_EN
// produces denormal results on underflow instead of flushing them to zero.
module fp_adder_normalizer
    import fp_adder_pkg::*;
#(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned EXP_W = 8,
    localparam int unsigned POS_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic             out_uflow,
    output logic             out_denorm
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic [POS_W-1:0] s1_pos;
    logic [POS_W-1:0] s1_shift;
    logic [POS_W-1:0] lzd_pos;

    logic              s2_valid;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [WIDTH-1:0]  mant_d;
    logic [EXP_W-1:0]  exp_d;
    logic              s1_uflow;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    fp_lzd #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_lzd (
        .mant (in_mant),
        .pos  (lzd_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_pos   <= '0;
            s1_shift <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant  <= in_mant;
                s1_exp   <= in_exp;
                s1_pos   <= lzd_pos;
                s1_shift <= POS_W'(pos_to_shift(32'(lzd_pos), WIDTH));
            end
        end
    end

    // Result exponent would be below 1.
    assign s1_uflow = (32'(s1_shift) >= 32'(s1_exp));

`ifdef FP_ADDER_NORMALIZER_DENORM_EN
    logic [EXP_W-1:0] denorm_shift;
    assign denorm_shift = (s1_exp == '0) ? '0 : s1_exp - EXP_W'(1);
`endif

    always_comb begin
        flags_d = '0;
        mant_d  = s1_mant << s1_shift;
        exp_d   = s1_exp - EXP_W'(s1_shift);
        if (s1_mant == '0) begin
            mant_d             = '0;
            exp_d              = '0;
            flags_d[FLAG_ZERO] = 1'b1;
        end else if (s1_uflow) begin
`ifdef FP_ADDER_NORMALIZER_DENORM_EN
            mant_d               = s1_mant << denorm_shift;
            exp_d                = '0;
            flags_d[FLAG_DENORM] = 1'b1;
`else
            mant_d              = '0;
            exp_d               = '0;
            flags_d[FLAG_UFLOW] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_mant <= '0;
            out_exp  <= '0;
            out_pos  <= '0;
            flags_q  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_mant <= mant_d;
                out_exp  <= exp_d;
                out_pos  <= s1_pos;
                flags_q  <= flags_d;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_zero   = flags_q[FLAG_ZERO];
    assign out_uflow  = flags_q[FLAG_UFLOW];
    assign out_denorm = flags_q[FLAG_DENORM];

endmodule

// File: tb/tb_fp_adder_normalizer.sv
// Self-checking bench for fp_adder_normalizer (WIDTH=24, EXP_W=8): directed vectors,
// stalls and mid-flight reset, checked against a behavioural result queue.
module tb_fp_adder_normalizer;

    localparam int W = 24;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic [4:0]  pos;
        logic        z;
        logic        u;
        logic        d;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_pos;
    logic        out_zero;
    logic        out_uflow;
    logic        out_denorm;

    int n_cmp = 0;
    int n_err = 0;

    res_t q[$];
    res_t held_r;
    logic held = 1'b0;

    fp_adder_normalizer #(
        .WIDTH (24),
        .EXP_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_pos    (out_pos),
        .out_zero   (out_zero),
        .out_uflow  (out_uflow),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    // Value-level model: find the leading one by repeated halving, then apply the rules.
    function automatic res_t model(input logic [23:0] m, input logic [7:0] e);
        res_t        r;
        logic [23:0] t;
        int          p;
        int          sh;
        int          s;
        r = '0;
        t = m;
        p = 0;
        while (t != 0) begin
            t = t >> 1;
            p++;
        end
        r.pos = 5'(p);
        sh = W - p;
        if (m == 0) begin
            r.z = 1'b1;
        end else if (sh >= int'(e)) begin
`ifdef FP_ADDER_NORMALIZER_DENORM_EN
            s = (e == 0) ? 0 : int'(e) - 1;
            r.mant = m << s;
            r.d = 1'b1;
`else
            s = 0;
            r.u = 1'b1;
`endif
        end else begin
            r.mant = m << sh;
            r.exp  = e - 8'(sh);
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.mant = out_mant;
        r.exp  = out_exp;
        r.pos  = out_pos;
        r.z    = out_zero;
        r.u    = out_uflow;
        r.d    = out_denorm;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (out_valid && held) begin
                n_cmp++;
                if (dut_res() !== held_r) begin
                    n_err++;
                    $display("FAIL hold: got %h required %h", dut_res(), held_r);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat: got %h required none", dut_res());
                end else begin
                    if (dut_res() !== q[0]) begin
                        n_err++;
                        $display("FAIL beat: got %h required %h", dut_res(), q[0]);
                    end
                    void'(q.pop_front());
                end
                held = 1'b0;
            end else if (out_valid) begin
                held   = 1'b1;
                held_r = dut_res();
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_mant, in_exp));
            end
        end
    end

    task automatic do_one(input string name, input logic [23:0] m, input logic [7:0] e,
                          input logic [23:0] xm, input logic [7:0] xe, input logic [4:0] xp,
                          input logic xz, input logic xu, input logic xd);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mant   = m;
        in_exp    = e;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
        tick();
        check({name, "_lat2_valid"}, 64'(out_valid), 64'd1);
        check({name, "_mant"}, 64'(out_mant), 64'(xm));
        check({name, "_exp"}, 64'(out_exp), 64'(xe));
        check({name, "_pos"}, 64'(out_pos), 64'(xp));
        check({name, "_flags"}, 64'({out_zero, out_uflow, out_denorm}), 64'({xz, xu, xd}));
        tick();
    endtask

    logic [23:0] b_mant [8] = '{24'h000100, 24'h000000, 24'h000001, 24'h800000,
                                 24'hffffff, 24'h400000, 24'h000003, 24'h123456};
    logic [7:0]  b_exp  [8] = '{8'd100, 8'd77, 8'd10, 8'd1, 8'd5, 8'd1, 8'd200, 8'd0};
    logic        rdy_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int  k;
        logic hs;

        repeat (2) tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fields", 64'(dut_res()), 64'd0);

        do_one("norm", 24'h000100, 8'd100, 24'h800000, 8'd85, 5'd9, 1'b0, 1'b0, 1'b0);
        do_one("zero", 24'h000000, 8'd77, 24'h000000, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0);
`ifdef FP_ADDER_NORMALIZER_DENORM_EN
        do_one("uflow", 24'h000001, 8'd10, 24'h000200, 8'd0, 5'd1, 1'b0, 1'b0, 1'b1);
`else
        do_one("uflow", 24'h000001, 8'd10, 24'h000000, 8'd0, 5'd1, 1'b0, 1'b1, 1'b0);
`endif
        do_one("noshift", 24'h800000, 8'd1, 24'h800000, 8'd1, 5'd24, 1'b0, 1'b0, 1'b0);

        // Four back-to-back beats into a stalled output.
        k = 0;
        for (int c = 0; c < 40 && (k < 4 || q.size() != 0); c++) begin
            out_ready = (c >= 3);
            in_valid  = (k < 4);
            in_mant   = b_mant[k % 8];
            in_exp    = b_exp[k % 8];
            if (c == 2) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (c == 3) check("stall_accepted", 64'(k), 64'd2);
            hs = in_valid && in_ready;
            tick();
            if (hs) k++;
        end
        in_valid = 1'b0;
        check("b2b_accepted", 64'(k), 64'd4);
        check("b2b_drained", 64'(q.size()), 64'd0);

        // All eight vectors streamed under a ragged out_ready pattern.
        k = 0;
        for (int c = 0; c < 80 && (k < 8 || q.size() != 0); c++) begin
            out_ready = rdy_pat[c % 5];
            in_valid  = (k < 8);
            in_mant   = b_mant[k % 8];
            in_exp    = b_exp[k % 8];
            hs = in_valid && in_ready;
            tick();
            if (hs) k++;
        end
        in_valid = 1'b0;
        check("stream_accepted", 64'(k), 64'd8);
        check("stream_drained", 64'(q.size()), 64'd0);

        // Reset with two beats in flight; a beat offered during reset must vanish.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_mant  = b_mant[i];
            in_exp   = b_exp[i];
            tick();
        end
        rst      = 1'b1;
        in_mant  = 24'h00abcd;
        in_exp   = 8'd50;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        do_one("post_rst", 24'h0000f0, 8'd30, 24'hf00000, 8'd14, 5'd8, 1'b0, 1'b0, 1'b0);
        check("final_queue", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
